mem_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IFU) and load/store (LSU) requesters.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction fetch
// unit (IFU) and the load/store unit (LSU). Round-robin grant, one outstanding
// transaction, request fields latched at grant, response routed to the owner,
// optional response timeout that returns an error response.
module mem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   // IFU port (read only)
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_resp_data,
   output logic                ifu_resp_err,
   // LSU port
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_resp_data,
   output logic                lsu_resp_err,
   // memory port
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data
);

   localparam int MASK_W = DATA_W / 8;
   // Timer is at least 8 bits and always wide enough to hold TIMEOUT.
   localparam int TMR_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   localparam logic [TMR_W-1:0] TMR_MAX   = '1;
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;

   logic grant_ifu, grant_lsu;
   logic in_idle, in_req, in_wait;
   logic timeout_hit, resp_fire;

   // Round-robin: a lone requester always wins; on a tie the requester that
   // was not granted last time wins.
   assign grant_ifu = ifu_req_valid && (!lsu_req_valid || last_grant_q == OWN_LSU);
   assign grant_lsu = lsu_req_valid && (!ifu_req_valid || last_grant_q == OWN_IFU);

   // Handshake and response outputs are held low while reset is asserted.
   assign in_idle = !rst && state_q == ST_IDLE;
   assign in_req  = !rst && state_q == ST_REQ;
   assign in_wait = !rst && state_q == ST_WAIT;

   // A real response in the expiry cycle takes priority over the timeout.
   assign timeout_hit = (TIMEOUT != 0) && in_wait && (timer_q == TMR_LIMIT) && !mem_resp_valid;
   assign resp_fire   = in_wait && (mem_resp_valid || timeout_hit);

   assign ifu_req_ready = in_idle && grant_ifu;
   assign lsu_req_ready = in_idle && grant_lsu;

   assign mem_req_valid = in_req;
   assign mem_req_addr  = addr_q;
   assign mem_req_wen   = wen_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;

   // Memory data is passed only on a genuine response; timeout responses carry zero.
   assign ifu_resp_valid = resp_fire && owner_q == OWN_IFU;
   assign ifu_resp_err   = ifu_resp_valid && timeout_hit;
   assign ifu_resp_data  = (ifu_resp_valid && mem_resp_valid) ? mem_resp_data : '0;

   assign lsu_resp_valid = resp_fire && owner_q == OWN_LSU;
   assign lsu_resp_err   = lsu_resp_valid && timeout_hit;
   assign lsu_resp_data  = (lsu_resp_valid && mem_resp_valid) ? mem_resp_data : '0;

   // Next-state logic: grant and latch in IDLE, issue in REQ, wait/time out in WAIT.
   always_comb begin
      // NOTE: every variable gets a hold default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_ifu) begin
               owner_d      = OWN_IFU;
               last_grant_d = OWN_IFU;
               addr_d       = ifu_req_addr;
               wen_d        = 1'b0;
               wdata_d      = '0;
               wmask_d      = '0;
               state_d      = ST_REQ;
            end else if (grant_lsu) begin
               owner_d      = OWN_LSU;
               last_grant_d = OWN_LSU;
               addr_d       = lsu_req_addr;
               wen_d        = lsu_req_wen;
               wdata_d      = lsu_req_wdata;
               wmask_d      = lsu_req_wmask;
               state_d      = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               timer_d = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (timer_q != TMR_MAX) begin
               timer_d = timer_q + 1'b1;
            end
            if (resp_fire) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_IFU;
         last_grant_q <= OWN_LSU;
         timer_q      <= '0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with TIMEOUT=4. Inputs are
// driven 1 time unit after each rising edge, outputs sampled 1 unit later.
module tb_mem_arbiter;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_req_addr;
   logic              ifu_resp_valid;
   logic [DATA_W-1:0] ifu_resp_data;
   logic              ifu_resp_err;
   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_req_addr;
   logic              lsu_req_wen;
   logic [DATA_W-1:0] lsu_req_wdata;
   logic [7:0]        lsu_req_wmask;
   logic              lsu_resp_valid;
   logic [DATA_W-1:0] lsu_resp_data;
   logic              lsu_resp_err;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_wen;
   logic [DATA_W-1:0] mem_req_wdata;
   logic [7:0]        mem_req_wmask;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_req_addr   (ifu_req_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_data  (ifu_resp_data),
      .ifu_resp_err   (ifu_resp_err),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_req_addr   (lsu_req_addr),
      .lsu_req_wen    (lsu_req_wen),
      .lsu_req_wdata  (lsu_req_wdata),
      .lsu_req_wmask  (lsu_req_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_data  (lsu_resp_data),
      .lsu_resp_err   (lsu_resp_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Both requesters idle, memory quiet.
   task automatic check_quiet(input string tag);
      check({tag, " ifu_ready"}, 64'(ifu_req_ready), 64'd0);
      check({tag, " lsu_ready"}, 64'(lsu_req_ready), 64'd0);
      check({tag, " mem_valid"}, 64'(mem_req_valid), 64'd0);
      check({tag, " ifu_resp"},  64'(ifu_resp_valid), 64'd0);
      check({tag, " lsu_resp"},  64'(lsu_resp_valid), 64'd0);
   endtask

   initial begin
      rst            = 1'b1;
      ifu_req_valid  = 1'b0;
      ifu_req_addr   = '0;
      lsu_req_valid  = 1'b0;
      lsu_req_addr   = '0;
      lsu_req_wen    = 1'b0;
      lsu_req_wdata  = '0;
      lsu_req_wmask  = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;

      // ---------------- reset state ----------------
      tick();
      tick();
      #1;
      check_quiet("rst");
      check("rst ifu_err", 64'(ifu_resp_err), 64'd0);
      check("rst lsu_err", 64'(lsu_resp_err), 64'd0);
      rst = 1'b0;
      #1;
      check_quiet("post_rst");
      check("post_rst addr",  mem_req_addr, 64'd0);
      check("post_rst wdata", mem_req_wdata, 64'd0);
      check("post_rst wmask", 64'(mem_req_wmask), 64'd0);
      check("post_rst wen",   64'(mem_req_wen), 64'd0);

      // ---------------- 1: IFU only ----------------
      tick();
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 64'h8000_0000;
      #1;
      check("t1 ifu_ready", 64'(ifu_req_ready), 64'd1);
      check("t1 lsu_ready", 64'(lsu_req_ready), 64'd0);
      check("t1 mem_valid_same_cycle", 64'(mem_req_valid), 64'd0);
      tick();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      check("t1 mem_valid", 64'(mem_req_valid), 64'd1);
      check("t1 mem_addr",  mem_req_addr, 64'h8000_0000);
      check("t1 mem_wen",   64'(mem_req_wen), 64'd0);
      check("t1 mem_wmask", 64'(mem_req_wmask), 64'd0);
      check("t1 ifu_ready_req", 64'(ifu_req_ready), 64'd0);
      tick();
      mem_req_ready = 1'b0;
      #1;
      check("t1 wait_mem_valid", 64'(mem_req_valid), 64'd0);
      check("t1 wait_no_resp", 64'(ifu_resp_valid), 64'd0);
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h0010_0073;
      #1;
      check("t1 ifu_resp",  64'(ifu_resp_valid), 64'd1);
      check("t1 ifu_data",  ifu_resp_data, 64'h0010_0073);
      check("t1 ifu_err",   64'(ifu_resp_err), 64'd0);
      check("t1 lsu_resp",  64'(lsu_resp_valid), 64'd0);
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      #1;
      check_quiet("t1 after");

      // ---------------- 2/3: tie from reset, stall, LSU write ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 64'h8000_0004;
      lsu_req_valid = 1'b1;
      lsu_req_addr  = 64'h8000_1000;
      lsu_req_wen   = 1'b1;
      lsu_req_wdata = 64'hDEAD_BEEF;
      lsu_req_wmask = 8'h0F;
      #1;
      check("t2 tie1 ifu_ready", 64'(ifu_req_ready), 64'd1);
      check("t2 tie1 lsu_ready", 64'(lsu_req_ready), 64'd0);
      tick();
      ifu_req_valid = 1'b0;
      #1;
      // Memory stalls for 5 cycles: request held, both readies low.
      for (int i = 0; i < 5; i++) begin
         check("t3 stall mem_valid", 64'(mem_req_valid), 64'd1);
         check("t3 stall addr", mem_req_addr, 64'h8000_0004);
         check("t3 stall wen", 64'(mem_req_wen), 64'd0);
         check("t3 stall ifu_ready", 64'(ifu_req_ready), 64'd0);
         check("t3 stall lsu_ready", 64'(lsu_req_ready), 64'd0);
         tick();
         #1;
      end
      mem_req_ready = 1'b1;
      #1;
      check("t3 release mem_valid", 64'(mem_req_valid), 64'd1);
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h1111_2222;
      #1;
      check("t2 ifu_resp", 64'(ifu_resp_valid), 64'd1);
      check("t2 ifu_data", ifu_resp_data, 64'h1111_2222);
      check("t2 lsu_resp_while_ifu", 64'(lsu_resp_valid), 64'd0);
      check("t2 lsu_ready_in_wait", 64'(lsu_req_ready), 64'd0);
      tick();
      mem_resp_valid = 1'b0;
      ifu_req_valid  = 1'b1;
      ifu_req_addr   = 64'h8000_0008;
      #1;
      check("t2 tie2 lsu_ready", 64'(lsu_req_ready), 64'd1);
      check("t2 tie2 ifu_ready", 64'(ifu_req_ready), 64'd0);
      tick();
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      check("t2 lsu mem_valid", 64'(mem_req_valid), 64'd1);
      check("t2 lsu addr",  mem_req_addr, 64'h8000_1000);
      check("t2 lsu wen",   64'(mem_req_wen), 64'd1);
      check("t2 lsu wdata", mem_req_wdata, 64'hDEAD_BEEF);
      check("t2 lsu wmask", 64'(mem_req_wmask), 64'h0F);
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = '0;
      #1;
      check("t2 lsu_resp", 64'(lsu_resp_valid), 64'd1);
      check("t2 lsu_err",  64'(lsu_resp_err), 64'd0);
      check("t2 ifu_resp_while_lsu", 64'(ifu_resp_valid), 64'd0);
      tick();
      mem_resp_valid = 1'b0;
      lsu_req_valid  = 1'b1;
      lsu_req_addr   = 64'h8000_2000;
      lsu_req_wen    = 1'b0;
      lsu_req_wmask  = 8'h00;
      #1;
      check("t2 tie3 ifu_ready", 64'(ifu_req_ready), 64'd1);
      check("t2 tie3 lsu_ready", 64'(lsu_req_ready), 64'd0);
      tick();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;

      // ---------------- 4: timeout (TIMEOUT=4) ----------------
      mem_req_ready = 1'b1;
      #1;
      check("t4 mem_addr", mem_req_addr, 64'h8000_0008);
      check("t4 mem_wmask", 64'(mem_req_wmask), 64'd0);
      tick();
      mem_req_ready = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("t4 no_early_resp", 64'(ifu_resp_valid), 64'd0);
         tick();
         #1;
      end
      check("t4 timeout_resp", 64'(ifu_resp_valid), 64'd1);
      check("t4 timeout_err",  64'(ifu_resp_err), 64'd1);
      check("t4 timeout_data", ifu_resp_data, 64'd0);
      check("t4 lsu_resp", 64'(lsu_resp_valid), 64'd0);
      tick();
      #1;
      check_quiet("t4 back_idle");

      // ---------------- 4b: response in the expiry cycle wins ----------------
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 64'h8000_0030;
      #1;
      check("t4b ifu_ready", 64'(ifu_req_ready), 64'd1);
      tick();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h0000_CAFE;
      #1;
      check("t4b resp", 64'(ifu_resp_valid), 64'd1);
      check("t4b err",  64'(ifu_resp_err), 64'd0);
      check("t4b data", ifu_resp_data, 64'h0000_CAFE);
      tick();
      mem_resp_valid = 1'b0;

      // ---------------- 5: reset during WAIT, stale response ----------------
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 64'h8000_0010;
      tick();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst            = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h0000_0BAD;
      #1;
      check_quiet("t5 stale");
      check("t5 addr_cleared", mem_req_addr, 64'd0);
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      ifu_req_valid  = 1'b1;
      ifu_req_addr   = 64'h8000_0020;
      #1;
      check("t5 next ifu_ready", 64'(ifu_req_ready), 64'd1);
      tick();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      check("t5 next mem_addr", mem_req_addr, 64'h8000_0020);
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h1234_5678;
      #1;
      check("t5 next resp", 64'(ifu_resp_valid), 64'd1);
      check("t5 next data", ifu_resp_data, 64'h1234_5678);
      check("t5 next err",  64'(ifu_resp_err), 64'd0);
      tick();
      mem_resp_valid = 1'b0;

      // ---------------- 6: response while IDLE is ignored ----------------
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hFFFF_FFFF;
      #1;
      check_quiet("t6 idle_resp");
      check("t6 ifu_data", ifu_resp_data, 64'd0);
      tick();
      mem_resp_valid = 1'b0;
      #1;
      check_quiet("t6 after");
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 64'h8000_0040;
      #1;
      check("t6 still_idle ifu_ready", 64'(ifu_req_ready), 64'd1);
      tick();
      ifu_req_valid = 1'b0;
      #1;
      check("t6 req mem_valid", 64'(mem_req_valid), 64'd1);
      check("t6 req addr", mem_req_addr, 64'h8000_0040);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
